// File: rtl/ppi_strobed_port.sv
// Strobed parallel peripheral port: simple in/out plus STB/IBF input (FIFO-buffered)
// and OBF/ACK output handshaking, with interrupt and sticky overrun flags.
module ppi_strobed_port #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             inte,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] port_in,
  output logic [WIDTH-1:0] port_out,
  output logic             port_oe,
  input  logic             stb_n,
  input  logic             ack_n,
  output logic             ibf,
  output logic             obf_n,
  output logic             intr,
  output logic             ovr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    ModeSimpleIn  = 2'b00,
    ModeSimpleOut = 2'b01,
    ModeStbIn     = 2'b10,
    ModeStbOut    = 2'b11
  } mode_e;

  mode_e            r_mode, w_mode_d;
  logic             r_stb, r_ack;
  logic [WIDTH-1:0] r_out, w_out_d;
  logic [WIDTH-1:0] r_rdata, w_rdata_d;
  logic             r_obf_n, w_obf_n_d;
  logic             r_ovr, w_ovr_d;
  logic [AW-1:0]    r_wptr, w_wptr_d, r_rptr, w_rptr_d;
  logic [CW-1:0]    r_count, w_count_d;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_stb_fall, w_ack_fall, w_mode_chg, w_act;
  logic w_empty, w_full, w_push, w_pop, w_ovr_set;

  always_comb begin
    w_stb_fall = r_stb & ~stb_n;
    w_ack_fall = r_ack & ~ack_n;
    w_mode_chg = enable & (mode != r_mode);
    w_act      = enable & ~w_mode_chg;
    w_empty    = (r_count == '0);
    w_full     = (r_count == FULL_CNT);

    w_mode_d  = r_mode;
    w_out_d   = r_out;
    w_rdata_d = r_rdata;
    w_obf_n_d = r_obf_n;
    w_ovr_d   = r_ovr;
    w_wptr_d  = r_wptr;
    w_rptr_d  = r_rptr;
    w_count_d = r_count;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovr_set = 1'b0;

    if (w_mode_chg) begin
      w_mode_d  = mode_e'(mode);
      w_wptr_d  = '0;
      w_rptr_d  = '0;
      w_count_d = '0;
      w_obf_n_d = 1'b1;
      w_ovr_d   = 1'b0;
    end else if (w_act) begin
      unique case (r_mode)
        ModeSimpleIn: begin
          if (rd) w_rdata_d = port_in;
        end
        ModeSimpleOut: begin
          if (wr) w_out_d = wdata;
          if (rd) w_rdata_d = r_out;
        end
        ModeStbIn: begin
          w_pop     = rd & ~w_empty;
          // A full FIFO still accepts a push when the same cycle frees a slot.
          w_push    = w_stb_fall & (~w_full | w_pop);
          w_ovr_set = w_stb_fall & w_full & ~w_pop;
          if (w_pop) w_rdata_d = r_mem[r_rptr];
        end
        ModeStbOut: begin
          if (wr) begin
            w_out_d   = wdata;
            w_obf_n_d = 1'b0;
            w_ovr_set = ~r_obf_n;
          end else if (w_ack_fall) begin
            w_obf_n_d = 1'b1;
          end
          if (rd) w_rdata_d = r_out;
        end
        default: ;
      endcase

      if (w_push) w_wptr_d = r_wptr + AW'(1);
      if (w_pop)  w_rptr_d = r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + CW'(1);
        2'b01:   w_count_d = r_count - CW'(1);
        default: w_count_d = r_count;
      endcase

      if (w_ovr_set)  w_ovr_d = 1'b1;
      else if (rd)    w_ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= ModeSimpleIn;
      r_stb   <= 1'b1;
      r_ack   <= 1'b1;
      r_out   <= '0;
      r_rdata <= '0;
      r_obf_n <= 1'b1;
      r_ovr   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_mode  <= w_mode_d;
      r_stb   <= stb_n;
      r_ack   <= ack_n;
      r_out   <= w_out_d;
      r_rdata <= w_rdata_d;
      r_obf_n <= w_obf_n_d;
      r_ovr   <= w_ovr_d;
      r_wptr  <= w_wptr_d;
      r_rptr  <= w_rptr_d;
      r_count <= w_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= port_in;
  end

  assign port_out = r_out;
  // Pins stay released for the whole reset, even if enable/mode are already driven.
  assign port_oe  = enable & mode[0] & ~rst;
  assign rdata    = r_rdata;
  assign ibf      = ~w_empty;
  assign obf_n    = r_obf_n;
  assign ovr      = r_ovr;
  assign intr     = enable & inte & ((r_mode == ModeStbIn)  ? ibf :
                                     (r_mode == ModeStbOut) ? r_obf_n : 1'b0);

endmodule

// File: tb/tb_ppi_strobed_port.sv
// Directed self-checking bench for ppi_strobed_port (WIDTH=8, DEPTH=4).
module tb_ppi_strobed_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic       inte;
  logic       wr;
  logic [7:0] wdata;
  logic       rd;
  logic [7:0] rdata;
  logic [7:0] port_in;
  logic [7:0] port_out;
  logic       port_oe;
  logic       stb_n;
  logic       ack_n;
  logic       ibf;
  logic       obf_n;
  logic       intr;
  logic       ovr;

  int n_checks = 0;
  int n_errors = 0;

  ppi_strobed_port #(.WIDTH(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .mode     (mode),
    .inte     (inte),
    .wr       (wr),
    .wdata    (wdata),
    .rd       (rd),
    .rdata    (rdata),
    .port_in  (port_in),
    .port_out (port_out),
    .port_oe  (port_oe),
    .stb_n    (stb_n),
    .ack_n    (ack_n),
    .ibf      (ibf),
    .obf_n    (obf_n),
    .intr     (intr),
    .ovr      (ovr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [7:0] d);
    wr = 1'b1; wdata = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic do_rd();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic stb_pulse(input logic [7:0] d);
    stb_n = 1'b0; port_in = d;
    tick();
    stb_n = 1'b1;
    tick();
  endtask

  task automatic ack_pulse();
    ack_n = 1'b0;
    tick();
    ack_n = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'b00; inte = 1'b0; wr = 1'b0; wdata = '0;
    rd = 1'b0; port_in = '0; stb_n = 1'b1; ack_n = 1'b1;
    tick(); tick();
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_port_out", port_out, 0);
    check_eq("rst_port_oe", port_oe, 0);
    check_eq("rst_ibf", ibf, 0);
    check_eq("rst_obf_n", obf_n, 1);
    check_eq("rst_intr", intr, 0);
    check_eq("rst_ovr", ovr, 0);
    rst = 1'b0;
    tick();

    // Simple output
    mode = 2'b01; enable = 1'b1;
    tick();
    check_eq("so_oe", port_oe, 1);
    do_wr(8'hA5);
    check_eq("so_port_out", port_out, 8'hA5);
    do_rd();
    check_eq("so_readback", rdata, 8'hA5);

    // Simple input
    mode = 2'b00;
    tick();
    check_eq("si_oe", port_oe, 0);
    port_in = 8'h3C;
    do_rd();
    check_eq("si_rdata", rdata, 8'h3C);
    do_wr(8'hFF);
    check_eq("si_wr_ignored", port_out, 8'hA5);

    // Strobed input: overrun on fifth push
    mode = 2'b10; inte = 1'b1;
    tick();
    check_eq("sti_empty_intr", intr, 0);
    for (int i = 1; i <= 5; i++) stb_pulse(8'(i));
    check_eq("sti_ibf", ibf, 1);
    check_eq("sti_intr", intr, 1);
    check_eq("sti_ovr", ovr, 1);
    for (int i = 1; i <= 4; i++) begin
      do_rd();
      check_eq("sti_pop", rdata, 32'(i));
      if (i == 1) check_eq("sti_ovr_clr", ovr, 0);
      if (i == 3) check_eq("sti_ibf_mid", ibf, 1);
    end
    check_eq("sti_ibf_empty", ibf, 0);
    check_eq("sti_intr_empty", intr, 0);
    do_rd();
    check_eq("sti_empty_rd", rdata, 8'h04);

    // Full FIFO: push and pop in the same cycle
    for (int i = 0; i < 4; i++) stb_pulse(8'h11 + 8'(i));
    check_eq("full_ovr0", ovr, 0);
    stb_n = 1'b0; port_in = 8'h15; rd = 1'b1;
    tick();
    stb_n = 1'b1; rd = 1'b0;
    check_eq("full_pp_rdata", rdata, 8'h11);
    check_eq("full_pp_ovr", ovr, 0);
    for (int i = 0; i < 4; i++) begin
      do_rd();
      check_eq("full_pp_drain", rdata, 8'h12 + 32'(i));
      if (i == 2) check_eq("full_pp_cnt", ibf, 1);
    end
    check_eq("full_pp_ibf", ibf, 0);

    // Mode change flushes FIFO
    stb_pulse(8'h21);
    stb_pulse(8'h22);
    check_eq("flush_pre_ibf", ibf, 1);
    mode = 2'b11;
    tick();
    check_eq("flush_ibf", ibf, 0);
    check_eq("flush_ovr", ovr, 0);
    check_eq("sto_idle_intr", intr, 1);

    // Strobed output
    do_wr(8'h55);
    check_eq("sto_obf", obf_n, 0);
    check_eq("sto_intr0", intr, 0);
    check_eq("sto_port_out", port_out, 8'h55);
    check_eq("sto_ovr0", ovr, 0);
    ack_pulse();
    check_eq("sto_ack_obf", obf_n, 1);
    check_eq("sto_ack_intr", intr, 1);
    wr = 1'b1; wdata = 8'h66; ack_n = 1'b0;
    tick();
    wr = 1'b0;
    check_eq("sto_wr_wins", obf_n, 0);
    check_eq("sto_wr_wins_ovr", ovr, 0);
    ack_n = 1'b1;
    tick();
    do_wr(8'h77);
    check_eq("sto_overwrite_ovr", ovr, 1);
    check_eq("sto_overwrite_out", port_out, 8'h77);
    do_rd();
    check_eq("sto_rd", rdata, 8'h77);
    check_eq("sto_rd_clr_ovr", ovr, 0);
    ack_pulse();
    check_eq("sto_ack2_obf", obf_n, 1);

    // Disabled: outputs gated, state held
    enable = 1'b0;
    #1;
    check_eq("dis_oe", port_oe, 0);
    check_eq("dis_intr", intr, 0);
    do_wr(8'h99);
    check_eq("dis_port_out", port_out, 8'h77);
    check_eq("dis_obf", obf_n, 1);
    enable = 1'b1;
    tick();

    // Mode change clears ovr and obf_n
    do_wr(8'h88);
    do_wr(8'hAA);
    check_eq("mc_pre_ovr", ovr, 1);
    mode = 2'b01;
    tick();
    check_eq("mc_ovr", ovr, 0);
    check_eq("mc_obf", obf_n, 1);
    check_eq("mc_port_out", port_out, 8'hAA);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_port_out", port_out, 0);
    check_eq("arst_rdata", rdata, 0);
    check_eq("arst_oe", port_oe, 0);
    check_eq("arst_obf", obf_n, 1);
    check_eq("arst_intr", intr, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ppi_strobed_port.md
Name: ppi_strobed_port

Overview:
- Parametrised next-generation PPI port with four modes: simple input, simple output, strobed input, and strobed output.
- Strobed input uses STB/IBF handshaking; strobed output uses OBF/ACK handshaking.
- Strobed input is buffered by a small FIFO. Interrupt and overrun flags are provided.
- The block sits between the CPU data bus and the peripheral pins. Pad tri-stating is done at top level from port_oe.

Parameters:
- WIDTH, 8: port and data width in bits.
- DEPTH, 4: strobed-input FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  block enable
- mode  in  2  00 simple in, 01 simple out, 10 strobed in, 11 strobed out
- inte  in  1  interrupt enable
- wr  in  1  CPU write strobe, one cycle per write
- wdata  in  WIDTH  CPU write data
- rd  in  1  CPU read strobe, one cycle per read
- rdata  out  WIDTH  CPU read data, registered
- port_in  in  WIDTH  pin input value
- port_out  out  WIDTH  pin output value
- port_oe  out  1  pin drive enable
- stb_n  in  1  peripheral input strobe, active low
- ack_n  in  1  peripheral acknowledge, active low
- ibf  out  1  input buffer full (FIFO non-empty)
- obf_n  out  1  output buffer full, active low
- intr  out  1  interrupt request
- ovr  out  1  sticky overrun flag

Behaviour:
- Reset values:
  - rdata = 0, port_out = 0, port_oe = 0.
  - FIFO empty, ibf = 0, obf_n = 1, intr = 0, ovr = 0.
  - stb_n/ack_n history registers = 1.
- Synchronisation: stb_n and ack_n are synchronous to clk; synchronisers live outside this block.
- Edge detection:
  - Falling edge = previous sample 1 and current sample 0.
  - History registers update every cycle, including when enable = 0.
- enable = 0:
  - port_oe = 0.
  - wr, rd and strobe edges are ignored.
  - All state is held.
  - intr = 0.
- Mode change:
  - The mode is registered internally.
  - When a mode value differs from the registered one with enable = 1, the next clock flushes the FIFO, sets obf_n = 1 and clears ovr.
  - No wr/rd/edge is acted on in that cycle.
- port_oe = enable & mode[0]. port_out always equals the output register.
- Mode 00 (simple input):
  - rd -> rdata <= port_in, visible the cycle after rd.
  - wr is ignored.
- Mode 01 (simple output):
  - wr -> output register <= wdata, visible on port_out the next cycle.
  - rd -> rdata <= output register (readback).
- Mode 10 (strobed input):
  - stb_n falling edge pushes port_in sampled in that cycle.
  - ibf = FIFO non-empty.
  - rd pops the head into rdata (latency 1).
  - rd when empty: no pop, rdata unchanged.
  - Push when full without a same-cycle pop: data dropped, ovr <= 1.
  - Push when full with a same-cycle pop: both occur, count unchanged.
  - Push and rd with FIFO empty: push accepted, rd is an empty read (rdata unchanged).
  - Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
  - intr = inte & ibf.
- Mode 11 (strobed output):
  - wr -> output register <= wdata and obf_n <= 0.
  - ack_n falling edge -> obf_n <= 1.
  - wr and ack edge in the same cycle: wr wins, obf_n = 0.
  - wr while obf_n = 0: data overwritten, ovr <= 1.
  - rd -> rdata <= output register.
  - intr = inte & obf_n.
- ovr: sticky; cleared by rd in any mode (clear wins over a same-cycle set only if no new overrun occurs that cycle), by mode change, or by rst.
- rst asserted mid-operation immediately forces all reset values, regardless of clk.

Test Plan:
- Reset, then mode=01, enable=1, wr with wdata=0xA5 -> next cycle port_out=0xA5, port_oe=1; rd -> rdata=0xA5.
- mode=00, port_in=0x3C, rd -> rdata=0x3C one cycle later; port_oe=0; wr with wdata=0xFF leaves port_out unchanged.
- mode=10, DEPTH=4, inte=1, five stb_n pulses carrying 0x01..0x05 -> ibf=1, intr=1, ovr=1; four rd -> 0x01..0x04 in order; ibf=0 after the last; a fifth rd leaves rdata=0x04.
- mode=11, wr with wdata=0x55 -> obf_n=0, intr=0; ack_n pulse -> obf_n=1, intr=1; wr in the same cycle as an ack_n falling edge -> obf_n stays 0.
- FIFO full, stb_n falling edge in the same cycle as rd -> no overrun, count stays 4, head advances.
- Mode 10 holding 2 entries, then mode changed to 11 -> FIFO flushed, ibf=0, ovr=0; asserting rst between clk edges -> outputs go to reset values immediately.
